// File: rtl/axi4_lite_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_mul_arbiter
// Purpose  : Round-robin arbiter sharing one AXI4-lite multiplier slave among
//            NREQ clients. It is the only AXI4-lite master toward the slave.
//            For each job it writes the operand bytes of a and b, reads the
//            product bytes back, and returns the product with a done pulse.
// Ports    : clk, rst          clock, synchronous active-high reset
//            i_req             level request per client, held until o_done
//            i_a, i_b          packed operands, client i at [i*SZ +: SZ]
//            o_done, o_err     one-cycle completion pulse / failure flag
//            o_res, o_busy     product (held between jobs) / job in flight
//            o_aw*, o_w*, i_b*, o_ar*, i_r*   AXI4-lite master (resp 1 = ok)
// Revision : 1.0  initial release
// ============================================================================
module axi4_lite_mul_arbiter #(
  parameter int NREQ = 2,
  parameter int SZ   = 32,
  parameter int DSZ  = 8,
  parameter int ASZ  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     i_req,
  input  logic [NREQ*SZ-1:0]  i_a,
  input  logic [NREQ*SZ-1:0]  i_b,
  output logic [NREQ-1:0]     o_done,
  output logic                o_err,
  output logic [2*SZ-1:0]     o_res,
  output logic                o_busy,
  output logic [ASZ-1:0]      o_awaddr,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [DSZ-1:0]      o_wdata,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic                i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  output logic [ASZ-1:0]      o_araddr,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [DSZ-1:0]      i_rdata,
  input  logic                i_rvalid,
  output logic                o_rready,
  input  logic                i_rresp
);

  localparam int c_B     = SZ / DSZ;
  localparam int c_NBEAT = 2 * c_B;            // write beats == read beats
  localparam int c_BW    = $clog2(c_NBEAT);
  localparam int c_PW    = $clog2(NREQ);
  localparam logic [c_BW-1:0] c_LAST  = c_BW'(c_NBEAT - 1);
  localparam logic [ASZ-1:0]  c_RBASE = ASZ'(c_NBEAT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RD    = 3'd3,
    S_RRESP = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_PW-1:0]   r_ptr;
  logic [c_PW-1:0]   r_grant;
  logic [SZ-1:0]     r_a;
  logic [SZ-1:0]     r_b;
  logic [c_BW-1:0]   r_beat;
  logic              r_aw_done;
  logic              r_w_done;
  logic              r_fail;
  logic [2*SZ-1:0]   r_rbuf;
  logic [2*SZ-1:0]   r_res;

  logic              w_found;
  logic [c_PW-1:0]   w_win;
  logic [c_PW-1:0]   w_ptr_nxt;
  logic [2*SZ-1:0]   w_ops;
  logic [2*SZ-1:0]   w_rbuf_nxt;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_aw_fin;
  logic              w_w_fin;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && i_req[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = c_PW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign w_ptr_nxt = (w_win == c_PW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  // Operand bytes a then b form one contiguous little-endian byte stream.
  assign w_ops = {r_b, r_a};

  always_comb begin
    w_rbuf_nxt = r_rbuf;
    w_rbuf_nxt[int'(r_beat)*DSZ +: DSZ] = i_rdata;
  end

  assign w_aw_hs  = o_awvalid & i_awready;
  assign w_w_hs   = o_wvalid & i_wready;
  // A channel counts as finished if it handshook earlier or does so now.
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and outputs
  always_comb begin
    w_state_nxt = r_state;
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_bready    = 1'b0;
    o_arvalid   = 1'b0;
    o_rready    = 1'b0;
    o_done      = '0;
    o_err       = 1'b0;
    o_busy      = (r_state != S_IDLE);
    o_awaddr    = ASZ'(r_beat);
    o_wdata     = w_ops[int'(r_beat)*DSZ +: DSZ];
    o_araddr    = c_RBASE + ASZ'(r_beat);
    o_res       = r_res;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_WR;
      end
      S_WR: begin
        o_awvalid = !r_aw_done;
        o_wvalid  = !r_w_done;
        if (w_aw_fin && w_w_fin) w_state_nxt = S_WRESP;
      end
      S_WRESP: begin
        o_bready = 1'b1;
        if (i_bvalid) begin
          if (!i_bresp)              w_state_nxt = S_DONE;
          else if (r_beat != c_LAST) w_state_nxt = S_WR;
          else                       w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        o_arvalid = 1'b1;
        if (i_arready) w_state_nxt = S_RRESP;
      end
      S_RRESP: begin
        o_rready = 1'b1;
        if (i_rvalid) begin
          if (!i_rresp || r_beat == c_LAST) w_state_nxt = S_DONE;
          else                              w_state_nxt = S_RD;
        end
      end
      S_DONE: begin
        o_done      = NREQ'(1) << r_grant;
        o_err       = r_fail;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_grant   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_beat    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_fail    <= 1'b0;
      r_rbuf    <= '0;
      r_res     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant   <= w_win;
            r_ptr     <= w_ptr_nxt;
            r_a       <= i_a[int'(w_win)*SZ +: SZ];
            r_b       <= i_b[int'(w_win)*SZ +: SZ];
            r_beat    <= '0;
            r_fail    <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        S_WR: begin
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        S_WRESP: begin
          if (i_bvalid) begin
            if (!i_bresp)              r_fail <= 1'b1;
            else if (r_beat != c_LAST) r_beat <= r_beat + 1'b1;
            else                       r_beat <= '0;
          end
        end
        S_RRESP: begin
          if (i_rvalid) begin
            if (!i_rresp) begin
              r_fail <= 1'b1;
            end else begin
              r_rbuf <= w_rbuf_nxt;
              // Publish the product only once every byte arrived cleanly.
              if (r_beat == c_LAST) r_res  <= w_rbuf_nxt;
              else                  r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
